// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: control bit positions,
// fault codes, FSM state encodings and the zero-register index.
package mem_stage_pkg;

  localparam int CTRL_REG_WRITE = 2;
  localparam int CTRL_MEM_READ  = 1;
  localparam int CTRL_MEM_WRITE = 0;

  localparam int XZR_IDX = 31;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_TIMEOUT  = 2'b10,
    FAULT_ILLEGAL  = 2'b11
  } fault_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  // Register-file write is dropped for XZR and for any faulted instruction
  function automatic logic wb_write_en(input logic reg_write, input logic is_xzr,
                                       input fault_t fault);
    return reg_write & ~is_xzr & (fault == FAULT_NONE);
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Clear/enable counter for the load-data wait; terminal flags the cycle whose
// increment brings the count up to TIMEOUT.
module mem_timeout_ctr #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != CW'(TIMEOUT)) begin
      count <= count + CW'(1);
    end
  end

  assign terminal = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores on a valid/ready data port and
// produces one registered write-back beat per accepted instruction.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int          DATA_W     = 64,
  parameter int          REG_ADDR_W = 5,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [DATA_W-1:0]     ex_alu_result,
  input  logic [DATA_W-1:0]     ex_store_data,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [2:0]            ex_ctrl,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_W-1:0]     dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic                  dmem_ready,
  input  logic                  dmem_rvalid,
  input  logic [DATA_W-1:0]     dmem_rdata,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  wb_reg_write,
  output logic [1:0]            wb_fault
);

  state_t                state, next_state;
  logic [DATA_W-1:0]     addr_q, wdata_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [2:0]            ctrl_q;

  logic                  latch, fire, fire_reg_write;
  logic [DATA_W-1:0]     fire_data;
  logic [REG_ADDR_W-1:0] fire_rd;
  fault_t                fire_fault;
  logic                  ctr_clear, ctr_en, ctr_tc;

  // Gating with rst_n keeps ex_ready low while reset is held
  assign ex_ready   = rst_n && (state == IDLE);
  assign dmem_req   = (state == REQ);
  assign dmem_we    = ctrl_q[CTRL_MEM_WRITE];
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (ctr_clear),
    .enable   (ctr_en),
    .terminal (ctr_tc)
  );

  always_comb begin
    next_state     = state;
    latch          = 1'b0;
    fire           = 1'b0;
    fire_data      = '0;
    fire_rd        = rd_q;
    fire_reg_write = ctrl_q[CTRL_REG_WRITE];
    fire_fault     = FAULT_NONE;
    ctr_clear      = 1'b0;
    ctr_en         = 1'b0;
    case (state)
      IDLE: begin
        if (ex_valid && ex_ready) begin
          fire_rd        = ex_rd;
          fire_data      = ex_alu_result;
          fire_reg_write = ex_ctrl[CTRL_REG_WRITE];
          if (!ex_ctrl[CTRL_MEM_READ] && !ex_ctrl[CTRL_MEM_WRITE]) begin
            fire = 1'b1;
          end else if (ex_ctrl[CTRL_MEM_READ] && ex_ctrl[CTRL_MEM_WRITE]) begin
            fire       = 1'b1;
            fire_fault = FAULT_ILLEGAL;
          end else if (ex_alu_result[2:0] != 3'b000) begin
            fire       = 1'b1;
            fire_fault = FAULT_MISALIGN;
          end else begin
            latch      = 1'b1;
            next_state = REQ;
          end
        end
      end
      REQ: begin
        if (dmem_ready) begin
          if (ctrl_q[CTRL_MEM_WRITE]) begin
            fire           = 1'b1;
            fire_data      = addr_q;
            fire_reg_write = 1'b0;
            next_state     = IDLE;
          end else if (ctrl_q[CTRL_MEM_READ]) begin
            if (dmem_rvalid) begin
              fire       = 1'b1;
              fire_data  = dmem_rdata;
              next_state = IDLE;
            end else begin
              ctr_clear  = 1'b1;
              next_state = WAIT_RD;
            end
          end
        end
      end
      WAIT_RD: begin
        ctr_en = 1'b1;
        // Data arriving on the timeout cycle still wins
        if (dmem_rvalid) begin
          fire       = 1'b1;
          fire_data  = dmem_rdata;
          next_state = IDLE;
        end else if (ctr_tc) begin
          fire       = 1'b1;
          fire_fault = FAULT_TIMEOUT;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      ctrl_q  <= '0;
    end else begin
      state <= next_state;
      if (latch) begin
        addr_q  <= ex_alu_result;
        wdata_q <= ex_store_data;
        rd_q    <= ex_rd;
        ctrl_q  <= ex_ctrl;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      wb_reg_write <= 1'b0;
      wb_fault     <= FAULT_NONE;
    end else begin
      wb_valid     <= fire;
      wb_reg_write <= fire && wb_write_en(fire_reg_write,
                                          fire_rd == REG_ADDR_W'(XZR_IDX),
                                          fire_fault);
      if (fire) begin
        wb_rd    <= fire_rd;
        wb_data  <= fire_data;
        wb_fault <= fire_fault;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected write-back beats into
// a scoreboard queue that an independent monitor drains on every wb_valid.
module tb_mem_stage;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    logic        chk_data;
    logic        rw;
    logic [1:0]  fault;
  } exp_t;

  logic        clk, rst_n;
  logic        ex_valid, ex_ready;
  logic [63:0] ex_alu_result, ex_store_data;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_ctrl;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic        dmem_ready, dmem_rvalid;
  logic [63:0] dmem_rdata;
  logic        wb_valid, wb_reg_write;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic [1:0]  wb_fault;

  exp_t sb[$];
  int   vectors_applied = 0;
  int   miscompares = 0;
  int   cyc = 0;

  mem_stage #(.DATA_W(64), .REG_ADDR_W(5), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_reg_write(wb_reg_write), .wb_fault(wb_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors_applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] alu, input logic [63:0] sdata,
                               input logic [4:0] rd, input logic [2:0] ctrl);
    ex_valid      = 1'b1;
    ex_alu_result = alu;
    ex_store_data = sdata;
    ex_rd         = rd;
    ex_ctrl       = ctrl;
  endtask

  task automatic expectBeat(input logic [4:0] rd, input logic [63:0] data,
                            input logic chk_data, input logic rw, input logic [1:0] fault);
    exp_t e;
    e.rd = rd; e.data = data; e.chk_data = chk_data; e.rw = rw; e.fault = fault;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write-back beat must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_wb_beat", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("wb_rd", 64'(wb_rd), 64'(e.rd));
        checkOutput("wb_reg_write", 64'(wb_reg_write), 64'(e.rw));
        checkOutput("wb_fault", 64'(wb_fault), 64'(e.fault));
        if (e.chk_data) checkOutput("wb_data", wb_data, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic got;
    int   enter_cyc;
    rst_n = 1'b0;
    ex_valid = 1'b0; ex_alu_result = '0; ex_store_data = '0; ex_rd = '0; ex_ctrl = '0;
    dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;

    // Reset state
    #2;
    checkOutput("rst_ex_ready", 64'(ex_ready), 64'd0);
    checkOutput("rst_dmem_req", 64'(dmem_req), 64'd0);
    checkOutput("rst_wb_valid", 64'(wb_valid), 64'd0);
    checkOutput("rst_wb_data", wb_data, 64'd0);
    #10 rst_n = 1'b1;
    #1 checkOutput("post_rst_ex_ready", 64'(ex_ready), 64'd1);

    // Back-to-back ALU ops, one beat per cycle
    for (int i = 0; i < 5; i++) begin
      tick();
      case (i)
        0: begin applyStimulus(64'h10, 0, 5'd3,  3'b100); expectBeat(5'd3,  64'h10, 1, 1, 2'b00); end
        1: begin applyStimulus(64'h20, 0, 5'd31, 3'b100); expectBeat(5'd31, 64'h20, 1, 0, 2'b00); end
        2: begin applyStimulus(64'h30, 0, 5'd4,  3'b000); expectBeat(5'd4,  64'h30, 1, 0, 2'b00); end
        3: begin applyStimulus(64'h44, 0, 5'd6,  3'b100); expectBeat(5'd6,  64'h44, 1, 1, 2'b00); end
        default: begin applyStimulus(64'h55, 0, 5'd7, 3'b100); expectBeat(5'd7, 64'h55, 1, 1, 2'b00); end
      endcase
      @(negedge clk);
      checkOutput("alu_ex_ready", 64'(ex_ready), 64'd1);
      if (i > 0) checkOutput("alu_wb_each_cycle", 64'(wb_valid), 64'd1);
    end
    tick();
    ex_valid = 1'b0;
    @(negedge clk) checkOutput("alu_last_beat", 64'(wb_valid), 64'd1);
    tick();
    @(negedge clk) checkOutput("alu_beat_single", 64'(wb_valid), 64'd0);

    // Load: ready after 2 REQ cycles, rvalid 3 cycles later
    tick();
    applyStimulus(64'h40, 0, 5'd5, 3'b110);
    expectBeat(5'd5, 64'hDEADBEEF, 1, 1, 2'b00);
    tick();
    ex_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      dmem_ready  = (c == 2);
      dmem_rvalid = (c == 0) || (c == 5);
      dmem_rdata  = (c == 5) ? 64'hDEADBEEF : 64'hBAD0BAD0;
      @(negedge clk);
      checkOutput("ld_ex_ready_low", 64'(ex_ready), 64'd0);
      checkOutput("ld_dmem_req", 64'(dmem_req), (c < 3) ? 64'd1 : 64'd0);
      if (c < 3) checkOutput("ld_dmem_addr", dmem_addr, 64'h40);
      tick();
    end
    dmem_ready = 1'b0; dmem_rvalid = 1'b0;
    @(negedge clk);
    checkOutput("ld_wb_valid", 64'(wb_valid), 64'd1);
    checkOutput("ld_ex_ready_back", 64'(ex_ready), 64'd1);

    // Zero-wait load: accept N, REQ N+1, beat N+2
    tick();
    applyStimulus(64'h80, 0, 5'd9, 3'b110);
    expectBeat(5'd9, 64'hCAFEF00D, 1, 1, 2'b00);
    tick();
    ex_valid = 1'b0;
    dmem_ready = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 64'hCAFEF00D;
    @(negedge clk) checkOutput("zw_dmem_req", 64'(dmem_req), 64'd1);
    tick();
    dmem_ready = 1'b0; dmem_rvalid = 1'b0;
    @(negedge clk) checkOutput("zw_wb_valid", 64'(wb_valid), 64'd1);

    // Store with ready held low 4 cycles; ex inputs change underneath
    tick();
    applyStimulus(64'h08, 64'h1234, 5'd0, 3'b001);
    expectBeat(5'd0, 64'h08, 1, 0, 2'b00);
    tick();
    ex_valid = 1'b0; ex_alu_result = 64'hFFFF_0000; ex_store_data = 64'h5555;
    for (int c = 0; c < 5; c++) begin
      dmem_ready = (c == 4);
      @(negedge clk);
      checkOutput("st_dmem_req", 64'(dmem_req), 64'd1);
      checkOutput("st_dmem_we", 64'(dmem_we), 64'd1);
      checkOutput("st_dmem_addr", dmem_addr, 64'h08);
      checkOutput("st_dmem_wdata", dmem_wdata, 64'h1234);
      tick();
    end
    dmem_ready = 1'b0;
    @(negedge clk);
    checkOutput("st_wb_valid", 64'(wb_valid), 64'd1);
    checkOutput("st_req_dropped", 64'(dmem_req), 64'd0);

    // Misaligned load, then illegal ctrl
    tick();
    applyStimulus(64'h43, 0, 5'd7, 3'b110);
    expectBeat(5'd7, 64'h0, 0, 0, 2'b01);
    tick();
    applyStimulus(64'h100, 0, 5'd8, 3'b011);
    expectBeat(5'd8, 64'h0, 0, 0, 2'b11);
    @(negedge clk);
    checkOutput("mis_no_req", 64'(dmem_req), 64'd0);
    checkOutput("mis_wb_valid", 64'(wb_valid), 64'd1);
    tick();
    ex_valid = 1'b0;
    @(negedge clk);
    checkOutput("ill_no_req", 64'(dmem_req), 64'd0);
    checkOutput("ill_wb_valid", 64'(wb_valid), 64'd1);

    // Load to XZR that never returns data -> timeout after 8 WAIT_RD cycles
    tick();
    applyStimulus(64'h200, 0, 5'd31, 3'b110);
    expectBeat(5'd31, 64'h0, 1, 0, 2'b10);
    tick();
    ex_valid = 1'b0;
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    enter_cyc = cyc;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (wb_valid) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("to_beat_seen", 64'(got), 64'd1);
    checkOutput("to_latency", 64'(cyc - enter_cyc), 64'd8);
    checkOutput("to_ex_ready", 64'(ex_ready), 64'd1);
    tick();
    applyStimulus(64'h77, 0, 5'd2, 3'b100);
    expectBeat(5'd2, 64'h77, 1, 1, 2'b00);
    tick();
    ex_valid = 1'b0;
    @(negedge clk) checkOutput("to_next_accepted", 64'(wb_valid), 64'd1);

    // Reset asserted while in REQ
    tick();
    applyStimulus(64'h300, 0, 5'd4, 3'b110);
    tick();
    ex_valid = 1'b0;
    @(negedge clk) checkOutput("rr_in_req", 64'(dmem_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rr_req_async_drop", 64'(dmem_req), 64'd0);
    checkOutput("rr_ex_ready_low", 64'(ex_ready), 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    checkOutput("rr_ex_ready_idle", 64'(ex_ready), 64'd1);
    checkOutput("rr_no_req", 64'(dmem_req), 64'd0);
    tick();
    tick();
    @(negedge clk);
    checkOutput("rr_no_wb", 64'(wb_valid), 64'd0);
    checkOutput("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
